// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_unit
// Brief    : Instruction-fetch stage. On a fetch request it issues a single
//            AXI4-Lite read at the current PC, latches the returned word
//            into the instruction register and pulses C_IMEM_DONE.
//            Optional macro IMEM_FAULT_EN adds C_IMEM_FAULT reporting for a
//            misaligned PC and for a non-OKAY read response.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
  parameter logic [2:0]  ARPROT_VAL  = 3'b100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              C_FETCH_REQ,
  input  logic [ADDR_W-1:0] PC,
  output logic              C_IMEM_DONE,
`ifdef IMEM_FAULT_EN
  output logic              C_IMEM_FAULT,
`endif
  output logic [31:0]       INSTR,
  output logic [6:0]        OPCODE,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  output logic [2:0]        M_ARPROT,
  input  logic [31:0]       M_RDATA,
  input  logic [1:0]        M_RRESP,
  input  logic              M_RVALID,
  output logic              M_RREADY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_done;
  logic [31:0]       r_instr;
`ifdef IMEM_FAULT_EN
  logic              r_fault;
  // A launch with a non-word-aligned PC never reaches the bus.
  logic              w_misaligned;
  // Any response other than OKAY leaves the instruction register untouched.
  logic              w_bad_resp;
  assign w_misaligned = (PC[1:0] != 2'b00);
  assign w_bad_resp   = (M_RRESP != 2'b00);
`else
  // Low PC bits and the read response carry no meaning without fault reporting.
  logic              w_unused;
  assign w_unused = ^{PC[1:0], M_RRESP};
`endif

  // Fetch sequencer: one outstanding read, AR and R phases strictly serial.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done    <= 1'b0;
      r_instr   <= RESET_INSTR;
`ifdef IMEM_FAULT_EN
      r_fault   <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
`ifdef IMEM_FAULT_EN
      r_fault <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (C_FETCH_REQ) begin
`ifdef IMEM_FAULT_EN
            if (w_misaligned) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_araddr  <= {PC[ADDR_W-1:2], 2'b00};
              r_arvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
`else
            r_araddr  <= {PC[ADDR_W-1:2], 2'b00};
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
`endif
          end
        end
        S_ADDR: begin
          // ARVALID/ARADDR are held until the slave accepts the address.
          if (M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (M_RVALID) begin
            r_rready <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
`ifdef IMEM_FAULT_EN
            if (w_bad_resp) begin
              r_fault <= 1'b1;
            end else begin
              r_instr <= M_RDATA;
            end
`else
            r_instr <= M_RDATA;
`endif
          end
        end
        S_DONE: begin
          // Request is ignored here so the control can leave IFETCH
          // before a new fetch could be launched.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign C_IMEM_DONE  = r_done;
`ifdef IMEM_FAULT_EN
  assign C_IMEM_FAULT = r_fault;
`endif
  assign INSTR        = r_instr;
  assign OPCODE       = r_instr[6:0];
  assign M_ARADDR     = r_araddr;
  assign M_ARVALID    = r_arvalid;
  assign M_ARPROT     = ARPROT_VAL;
  assign M_RREADY     = r_rready;

endmodule
`default_nettype wire
